// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - command, read-data and serial line bundle for spi_master
interface spi_master_if #(
  parameter int FRAME_WIDTH = 8
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [FRAME_WIDTH+1:0] cmd_data;
  logic                   rd_valid;
  logic [FRAME_WIDTH-1:0] rd_data;
  logic                   busy;
  logic                   SS_n;
  logic                   MOSI;
  logic                   MISO;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, rd_valid, rd_data, busy, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master: command frame out, optional read frame in; SPI_MASTER_CMD_BUFFER_EN adds a one-entry command buffer
module spi_master #(
  parameter int FRAME_WIDTH = 8,
  parameter int TURNAROUND  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);
  localparam int CMD_W   = FRAME_WIDTH + 2;
  localparam int CNT_MAX = (CMD_W > 16) ? CMD_W : 16;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, SEND, TURN, RECV, GAP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [1:0]             r_ctrl;
  logic [CMD_W-1:0]       r_tx;
  logic [FRAME_WIDTH-1:0] r_rx;
  logic [FRAME_WIDTH-1:0] r_rd_data;
  logic                   r_rd_valid;
  logic                   r_ss_n;
  logic                   r_mosi;
  logic [FRAME_WIDTH-1:0] w_rx_nxt;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_load;
  logic [CMD_W-1:0]       w_load_data;

`ifdef SPI_MASTER_CMD_BUFFER_EN
  logic                   r_buf_full;
  logic [CMD_W-1:0]       r_buf_data;

  // The buffer only ever holds a command while a frame is running, so it wins over cmd_data on a load
  assign w_ready     = rst_n && !r_buf_full;
  assign w_load_data = r_buf_full ? r_buf_data : bus.cmd_data;
`else
  assign w_ready     = rst_n && (r_state == IDLE);
  assign w_load_data = bus.cmd_data;
`endif

  assign w_accept = bus.cmd_valid && w_ready;
  assign w_rx_nxt = (r_rx << 1) | FRAME_WIDTH'(bus.MISO);

  // Next-state decode; w_load marks the edge where a command enters SEND
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (r_cnt == CW'(CMD_W - 1)) begin
          if (r_ctrl == 2'b11) w_state_nxt = (TURNAROUND > 0) ? TURN : RECV;
          else                 w_state_nxt = GAP;
        end
      end
      TURN: begin
        if (r_cnt == CW'(TURNAROUND - 1)) w_state_nxt = RECV;
      end
      RECV: begin
        if (r_cnt == CW'(FRAME_WIDTH - 1)) w_state_nxt = GAP;
      end
      GAP: begin
`ifdef SPI_MASTER_CMD_BUFFER_EN
        if (r_buf_full || w_accept) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bit counter, shift registers and registered serial/read outputs, all driven from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_ctrl     <= 2'b00;
      r_tx       <= '0;
      r_rx       <= '0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= (w_state_nxt == IDLE) || (w_state_nxt == GAP);

      if (w_load || (w_state_nxt != r_state)) r_cnt <= '0;
      else if (r_state != IDLE)               r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_ctrl <= w_load_data[CMD_W-1 -: 2];
        r_mosi <= w_load_data[CMD_W-1];
        r_tx   <= w_load_data << 1;
      end else if (w_state_nxt == SEND) begin
        r_mosi <= r_tx[CMD_W-1];
        r_tx   <= r_tx << 1;
      end

      if (r_state == RECV) begin
        r_rx <= w_rx_nxt;
        if (w_state_nxt == GAP) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= w_rx_nxt;
        end
      end
    end
  end

`ifdef SPI_MASTER_CMD_BUFFER_EN
  // A command accepted without loading straight into SEND is parked until the next GAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
    end else if (w_accept && !w_load) begin
      r_buf_full <= 1'b1;
      r_buf_data <= bus.cmd_data;
    end else if (w_load && r_buf_full) begin
      r_buf_full <= 1'b0;
    end
  end
`endif

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = rst_n && (r_state != IDLE);
  assign bus.SS_n      = r_ss_n;
  assign bus.MOSI      = r_mosi;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter TURNAROUND, default 1, range 0..15, meaning idle cycles between command bits and read-data bits.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command can be accepted.
REQ-007 SHALL have port cmd_data, input, FRAME_WIDTH+2, {ctrl[1:0], payload}.
REQ-008 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-009 SHALL have port rd_data, output, FRAME_WIDTH, captured read word.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port SS_n, output, 1, active-low slave select.
REQ-012 SHALL have port MOSI, output, 1, serial data to the slave.
REQ-013 SHALL have port MISO, input, 1, serial data from the slave.

Function
REQ-014 SHALL accept a command on the rising clk edge where cmd_valid && cmd_ready.
REQ-015 SHALL implement states IDLE, SEND, TURN, RECV and GAP, with all outputs registered except cmd_ready and busy.
- Transitions: IDLE->SEND on accept.
- SEND->GAP after the last bit when ctrl!=2'b11.
- SEND->TURN when ctrl==2'b11 and TURNAROUND>0; SEND->RECV directly when TURNAROUND==0.
- TURN->RECV after TURNAROUND cycles.
- RECV->GAP after FRAME_WIDTH samples.
- GAP->IDLE after 1 cycle.
REQ-016 SHALL in SEND drive SS_n=0 and MOSI=cmd_data bits MSB first (bit FRAME_WIDTH+1 down to 0), one bit per cycle.
- Timing: first bit appears in the cycle after acceptance.
- Length: exactly FRAME_WIDTH+2 cycles.
REQ-017 SHALL in TURN hold SS_n=0, MOSI=0.
REQ-018 SHALL in RECV hold SS_n=0, MOSI=0.
- Sampling: sample MISO at the end of each RECV cycle.
- Shift: MSB first into a shift register of FRAME_WIDTH bits.
REQ-019 SHALL update rd_data and pulse rd_valid high for exactly one cycle, the cycle after the last RECV sample (coincident with GAP).
REQ-020 SHALL hold rd_data stable between rd_valid pulses.
REQ-021 SHALL in GAP and IDLE drive SS_n=1, MOSI=0.
REQ-022 SHALL latch cmd_data at acceptance; changes on cmd_data afterwards SHALL NOT affect the frame in flight.
REQ-023 SHALL assert cmd_ready only in IDLE (base build).
REQ-024 SHALL ignore MISO outside RECV.

Reset
REQ-025 SHALL, when rst_n=0 at a clk edge, enter IDLE and set SS_n=1, MOSI=0, rd_valid=0, rd_data=0, and clear the bit counter and shift register.
REQ-026 SHALL hold cmd_ready=0 and busy=0 while rst_n=0.
REQ-027 SHALL abort any frame in progress on reset, raising SS_n in the cycle after the reset edge, with no rd_valid pulse.

Configuration
REQ-028 SHALL, when SPI_MASTER_CMD_BUFFER_EN is defined, include a one-entry command buffer.
- cmd_ready: high whenever the buffer is empty, including during a frame; not only in IDLE.
- Accept in IDLE with empty buffer: goes directly to SEND.
- Accept outside IDLE: stored in the buffer.
- GAP with buffer full: transitions to SEND (not IDLE) and empties the buffer; the one-cycle SS_n=1 gap is preserved.
- Reset empties the buffer.
REQ-029 SHALL, without SPI_MASTER_CMD_BUFFER_EN, contain no buffer and behave per REQ-023.

Verification
REQ-030 SHALL be checked with write-address cmd_data=10'h0A5 accepted at cycle 0 -> SS_n=0 cycles 1-10, MOSI=0,0,1,0,1,0,0,1,0,1, SS_n=1 cycle 11, no rd_valid.
REQ-031 SHALL be checked with read-data cmd_data=10'h300, TURNAROUND=1, MISO serially driving 8'h3C during RECV -> rd_valid single pulse at cycle 20, rd_data=8'h3C, SS_n=1 at cycle 20.
REQ-032 SHALL be checked with cmd_valid held high continuously (base build) -> cmd_ready=0 while busy, frames separated by exactly one SS_n=1 cycle plus one IDLE cycle.
REQ-033 SHALL be checked with rst_n=0 driven at cycle 5 of a read frame -> SS_n=1 next cycle, rd_valid stays 0, and the next command starts cleanly.
REQ-034 SHALL be checked with SPI_MASTER_CMD_BUFFER_EN defined and two write commands back-to-back -> second accepted during the first frame, SS_n high exactly one cycle between frames.
REQ-035 SHALL be checked with MISO toggled during SEND and GAP -> rd_data unchanged.
